alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  ID/EX issue stage that drives the ALU: decodes RV32I instructions into the
//  4-bit ALU control code, selects operands (register or immediate) and
//  registers them into a one-entry valid/ready pipeline slot.
//  Sits between register-file read and the ALU. Provides backpressure, flush
//  and illegal-opcode flagging.
// PARAMETERS
//  XLEN        32  datapath width
//  CTRL_W      4   ALU control width
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       asynchronous reset, active-low
//  in_valid    in   1       decode-side instruction valid
//  in_ready    out  1       stage can accept instruction this cycle
//  instr       in   32      raw instruction word
//  pc_in       in   XLEN    PC of instr
//  rs1_data    in   XLEN    register-file read port 1
//  rs2_data    in   XLEN    register-file read port 2
//  flush       in   1       kill slot contents (branch/trap redirect)
//  out_ready   in   1       ALU/EX side accepts slot
//  out_valid   out  1       slot holds an issued instruction
//  alu_ctrl    out  CTRL_W  ALU operation code
//  op_a        out  XLEN    ALU operand A (rs1_data)
//  op_b        out  XLEN    ALU operand B (rs2_data or sign-extended imm)
//  store_data  out  XLEN    rs2_data, for stores
//  rd_addr     out  5       destination register
//  reg_write   out  1       result writes rd
//  illegal     out  1       unsupported opcode/funct combination
//  pc_out      out  XLEN    PC of issued instruction
// BEHAVIOUR
//  Reset: every output register = 0; out_valid=0; in_ready=1 while rst_n=0
//   deasserted.
//  ALU codes: ADD=0000 SUB=0001 XOR=0111 OR=1000 AND=1001; nothing else emitted.
//  Decode (opcode = instr[6:0], f3 = [14:12], f7 = [31:25]):
//   0110011 R: f3=000,f7=0000000 ADD; f3=000,f7=0100000 SUB; f3=100 XOR;
//     f3=110 OR; f3=111 AND; all need f7=0 except SUB; op_b=rs2_data; reg_write=1.
//   0010011 I: f3=000 ADD, 100 XOR, 110 OR, 111 AND;
//     op_b=sext(instr[31:20]); reg_write=1.
//   0000011 load (f3 000/001/010/100/101): ADD, op_b=sext(instr[31:20]),
//     reg_write=1.
//   0100011 store (f3 000/001/010): ADD, op_b=sext({instr[31:25],instr[11:7]}),
//     reg_write=0, rd_addr=0.
//   Anything else: illegal=1, alu_ctrl=0000, reg_write=0, rd_addr=0, op_a/op_b=0;
//     still issued (out_valid=1) so EX can trap.
//  rd_addr=0 forces reg_write=0.
//  Handshake: in_ready = !out_valid | out_ready (combinational, no reg path
//   from in_valid). Load when in_valid & in_ready: all outputs registered,
//   out_valid=1 next cycle. Latency 1 cycle.
//  Slot drains on out_valid & out_ready with no load -> out_valid=0.
//  Simultaneous drain and load: new instruction replaces old, no bubble.
//  Stall: out_valid & !out_ready holds all outputs stable, in_ready=0.
//  flush: out_valid=0 next cycle, in_valid ignored that cycle, other output
//   regs may hold stale data; flush beats load and drain.
//  Async reset mid-transaction: slot cleared immediately, no partial issue.
// TESTING
//  1 R-type ADD x3,x1,x2, rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1,
//    alu_ctrl=0000, op_a=5, op_b=7, rd_addr=3, reg_write=1
//  2 SUB (f7=0100000) rs1=10, rs2=3 -> alu_ctrl=0001; ADDI imm=-1 ->
//    op_b=32'hFFFFFFFF
//  3 SW imm=-4 (instr[31:25]=7F, [11:7]=1C) -> op_b=32'hFFFFFFFC,
//    reg_write=0, alu_ctrl=0000
//  4 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen;
//    release -> back-to-back issue without bubble
//  5 flush with in_valid=1 and slot full -> out_valid=0 next cycle, no load
//  6 opcode 1100011 (branch) -> illegal=1, reg_write=0, out_valid=1;
//    rst_n low mid-stall -> all outputs 0 at once

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32I ALU/load/store instructions into ALU control
// and operands, held in a single valid/ready pipeline slot with flush support.
module alu_issue_stage #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic [XLEN-1:0]   pc_in,
   input  logic [XLEN-1:0]   rs1_data,
   input  logic [XLEN-1:0]   rs2_data,
   input  logic              flush,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [CTRL_W-1:0] alu_ctrl,
   output logic [XLEN-1:0]   op_a,
   output logic [XLEN-1:0]   op_b,
   output logic [XLEN-1:0]   store_data,
   output logic [4:0]        rd_addr,
   output logic              reg_write,
   output logic              illegal,
   output logic [XLEN-1:0]   pc_out
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [CTRL_W-1:0] ALU_ADD = CTRL_W'(4'b0000);
   localparam logic [CTRL_W-1:0] ALU_SUB = CTRL_W'(4'b0001);
   localparam logic [CTRL_W-1:0] ALU_XOR = CTRL_W'(4'b0111);
   localparam logic [CTRL_W-1:0] ALU_OR  = CTRL_W'(4'b1000);
   localparam logic [CTRL_W-1:0] ALU_AND = CTRL_W'(4'b1001);

   logic [6:0]        opcode_s;
   logic [2:0]        f3_s;
   logic [6:0]        f7_s;
   logic [XLEN-1:0]   imm_i_s;
   logic [XLEN-1:0]   imm_s_s;
   logic              unused_rs1_idx_s;

   logic              illegal_s;
   logic [CTRL_W-1:0] alu_ctrl_s;
   logic [XLEN-1:0]   op_a_s;
   logic [XLEN-1:0]   op_b_s;
   logic [4:0]        rd_s;
   logic              writes_rd_s;
   logic              reg_write_s;
   logic              load_s;

   logic              out_valid_r;
   logic [CTRL_W-1:0] alu_ctrl_r;
   logic [XLEN-1:0]   op_a_r;
   logic [XLEN-1:0]   op_b_r;
   logic [XLEN-1:0]   store_data_r;
   logic [4:0]        rd_addr_r;
   logic              reg_write_r;
   logic              illegal_r;
   logic [XLEN-1:0]   pc_out_r;

   assign opcode_s         = instr[6:0];
   assign f3_s             = instr[14:12];
   assign f7_s             = instr[31:25];
   assign imm_i_s          = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_s_s          = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
   // Register indices arrive pre-read as rs1_data/rs2_data; rs1 index is not needed here.
   assign unused_rs1_idx_s = ^instr[19:15];

   // Instruction decode and operand selection; illegal encodings issue with zeroed fields.
   always_comb begin
      illegal_s   = 1'b0;
      alu_ctrl_s  = ALU_ADD;
      op_a_s      = rs1_data;
      op_b_s      = rs2_data;
      rd_s        = instr[11:7];
      writes_rd_s = 1'b0;
      case (opcode_s)
         OP_R: begin
            writes_rd_s = 1'b1;
            case (f3_s)
               3'b000: begin
                  if (f7_s == 7'b0000000) begin
                     alu_ctrl_s = ALU_ADD;
                  end else if (f7_s == 7'b0100000) begin
                     alu_ctrl_s = ALU_SUB;
                  end else begin
                     illegal_s = 1'b1;
                  end
               end
               3'b100:  alu_ctrl_s = ALU_XOR;
               3'b110:  alu_ctrl_s = ALU_OR;
               3'b111:  alu_ctrl_s = ALU_AND;
               default: illegal_s  = 1'b1;
            endcase
            if ((f3_s != 3'b000) && (f7_s != 7'b0000000)) begin
               illegal_s = 1'b1;
            end else begin
               illegal_s = illegal_s;
            end
         end
         OP_I: begin
            writes_rd_s = 1'b1;
            op_b_s      = imm_i_s;
            case (f3_s)
               3'b000:  alu_ctrl_s = ALU_ADD;
               3'b100:  alu_ctrl_s = ALU_XOR;
               3'b110:  alu_ctrl_s = ALU_OR;
               3'b111:  alu_ctrl_s = ALU_AND;
               default: illegal_s  = 1'b1;
            endcase
         end
         OP_LOAD: begin
            writes_rd_s = 1'b1;
            op_b_s      = imm_i_s;
            case (f3_s)
               3'b000, 3'b001, 3'b010, 3'b100, 3'b101: alu_ctrl_s = ALU_ADD;
               default:                                illegal_s  = 1'b1;
            endcase
         end
         OP_STORE: begin
            op_b_s = imm_s_s;
            rd_s   = 5'd0;
            case (f3_s)
               3'b000, 3'b001, 3'b010: alu_ctrl_s = ALU_ADD;
               default:                illegal_s  = 1'b1;
            endcase
         end
         default: illegal_s = 1'b1;
      endcase
      if (illegal_s) begin
         alu_ctrl_s  = ALU_ADD;
         op_a_s      = '0;
         op_b_s      = '0;
         rd_s        = 5'd0;
         writes_rd_s = 1'b0;
      end else begin
         op_a_s = rs1_data;
      end
   end

   assign reg_write_s = writes_rd_s & (rd_s != 5'd0);
   assign in_ready    = ~out_valid_r | out_ready;
   assign load_s      = in_valid & in_ready & ~flush;

   // Pipeline slot: flush beats load and drain; a stall holds every field.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r  <= 1'b0;
         alu_ctrl_r   <= '0;
         op_a_r       <= '0;
         op_b_r       <= '0;
         store_data_r <= '0;
         rd_addr_r    <= 5'd0;
         reg_write_r  <= 1'b0;
         illegal_r    <= 1'b0;
         pc_out_r     <= '0;
      end else if (flush) begin
         out_valid_r <= 1'b0;
      end else if (load_s) begin
         out_valid_r  <= 1'b1;
         alu_ctrl_r   <= alu_ctrl_s;
         op_a_r       <= op_a_s;
         op_b_r       <= op_b_s;
         store_data_r <= rs2_data;
         rd_addr_r    <= rd_s;
         reg_write_r  <= reg_write_s;
         illegal_r    <= illegal_s;
         pc_out_r     <= pc_in;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign out_valid  = out_valid_r;
   assign alu_ctrl   = alu_ctrl_r;
   assign op_a       = op_a_r;
   assign op_b       = op_b_r;
   assign store_data = store_data_r;
   assign rd_addr    = rd_addr_r;
   assign reg_write  = reg_write_r;
   assign illegal    = illegal_r;
   assign pc_out     = pc_out_r;

endmodule
